// File: rtl/fifo_rd_sched_if.sv
// Read-side bundle of the async FIFO: pointer exchange, RAM read port,
// consumer request/grant and status.
interface fifo_rd_sched_if #(
  parameter int unsigned ADDRSIZE = 4,
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned NREQ     = 2
);
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [ADDRSIZE:0]   rptr;
  logic [ADDRSIZE-1:0] raddr;
  logic                ren;
  logic [DATASIZE-1:0] rdata_mem;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     gnt;
  logic [DATASIZE-1:0] rdata;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   rlevel;

  // Read controller side
  modport mst (
    input  rq2_wptr, rdata_mem, req,
    output rptr, raddr, ren, gnt, rdata, rempty, raempty, rlevel
  );

  // Environment side: synchronizer, RAM and consumers
  modport slv (
    output rq2_wptr, rdata_mem, req,
    input  rptr, raddr, ren, gnt, rdata, rempty, raempty, rlevel
  );
endinterface

// File: rtl/fifo_rd_sched.sv
// Read-side controller of the async FIFO: owns the read pointer and
// empty/level status, and shares the single read port among NREQ
// consumers by round-robin, delivering each word with a one-hot grant.
module fifo_rd_sched #(
  parameter int unsigned ADDRSIZE   = 4,
  parameter int unsigned DATASIZE   = 8,
  parameter int unsigned NREQ       = 2,
  parameter int unsigned AEMPTY_LVL = 1
) (
  input  logic         rclk,
  input  logic         rrst_n,
  fifo_rd_sched_if.mst rd_if
);

  localparam int unsigned PW = ADDRSIZE + 1;
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef logic [PW-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  ptr_t                rbin_q, rbin_d;
  ptr_t                rptr_q, rptr_d;
  ptr_t                rlevel_q, rlevel_d;
  logic                rempty_q, rempty_d;
  logic                raempty_q, raempty_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [DATASIZE-1:0] rdata_q, rdata_d;
  logic [IW-1:0]       last_q, last_d;

  logic [IW-1:0]       idx_c;
  logic [IW-1:0]       winner_c;
  logic                hit_c;
  logic                pop_c;

  // Round-robin pick: first requester scanning upward from last+1
  always_comb begin
    winner_c = last_q;
    hit_c    = 1'b0;
    idx_c    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx_c = IW'((32'(last_q) + k) % NREQ);
      if (!hit_c && rd_if.req[idx_c]) begin
        winner_c = idx_c;
        hit_c    = 1'b1;
      end
    end
  end

  // Pop is gated by the registered empty flag, so underflow cannot occur
  assign pop_c = hit_c && !rempty_q;

  // Next pointer, status and delivery registers
  always_comb begin
    rbin_d    = rbin_q + PW'(pop_c);
    rptr_d    = bin2gray(rbin_d);
    rlevel_d  = gray2bin(rd_if.rq2_wptr) - rbin_d;
    rempty_d  = (rptr_d == rd_if.rq2_wptr);
    raempty_d = (rlevel_d <= PW'(AEMPTY_LVL));
    gnt_d     = '0;
    rdata_d   = rdata_q;
    last_d    = last_q;
    if (pop_c) begin
      gnt_d   = NREQ'(1) << winner_c;
      rdata_d = rd_if.rdata_mem;
      last_d  = winner_c;
    end
  end

  // State registers; reset leaves consumer 0 with first priority
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      gnt_q     <= '0;
      rdata_q   <= '0;
      last_q    <= IW'(NREQ - 1);
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rptr_d;
      rlevel_q  <= rlevel_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
      gnt_q     <= gnt_d;
      rdata_q   <= rdata_d;
      last_q    <= last_d;
    end
  end

  // Output mapping; ren and raddr feed the RAM in the pop cycle
  assign rd_if.ren     = pop_c;
  assign rd_if.raddr   = rbin_q[ADDRSIZE-1:0];
  assign rd_if.rptr    = rptr_q;
  assign rd_if.rlevel  = rlevel_q;
  assign rd_if.rempty  = rempty_q;
  assign rd_if.raempty = raempty_q;
  assign rd_if.gnt     = gnt_q;
  assign rd_if.rdata   = rdata_q;

endmodule
